clic_gateway: RTL

- Per-source interrupt gateway for the CLIC. It conditions raw interrupt lines according to each source's trigger attribute: positive or negative, and level or edge.
- It owns the pending (IP) state for every source. It merges software IP writes and core acknowledges into that state.
- It drives register-file update strobes and the effective pending vector seen by the arbiter.
- It sits between the interrupt sources / register file and the CLIC arbiter.
- Supersedes the fixed positive-only adapter: all four trigger modes, hardware clear on claim, registered update strobes.

---
 rtl/clic_gateway_pkg.sv | 42 ++++
 rtl/clic_gateway_if.sv | 26 ++
 rtl/clic_gateway_cell.sv | 67 ++++++
 rtl/clic_gateway.sv | 43 ++++
 4 files changed

// File: rtl/clic_gateway_pkg.sv
// Shared types, trigger encodings and the pending-bit next-state rule for the CLIC gateway.
// Optional input synchronizer is enabled with `define CLIC_GATEWAY_SYNC_EN.
package clic_gateway_pkg;

   typedef struct packed {
      logic neg;
      logic edge_en;
   } trig_t;

   localparam logic [1:0] TRIG_LEVEL_POS = 2'b00;
   localparam logic [1:0] TRIG_EDGE_POS  = 2'b01;
   localparam logic [1:0] TRIG_LEVEL_NEG = 2'b10;
   localparam logic [1:0] TRIG_EDGE_NEG  = 2'b11;

   // Edge mode priority: event sets, then claim clears, then software write, else hold.
   function automatic logic gw_pend_next(
      input trig_t trig,
      input logic  irq,
      input logic  prev,
      input logic  ack_hit,
      input logic  sw_we,
      input logic  sw_wd,
      input logic  pend
   );
      logic evt;
      logic nxt;
      evt = trig.neg ? (~irq & prev) : (irq & ~prev);
      if (!trig.edge_en) begin
         nxt = irq ^ trig.neg;
      end else if (evt) begin
         nxt = 1'b1;
      end else if (ack_hit) begin
         nxt = 1'b0;
      end else if (sw_we) begin
         nxt = sw_wd;
      end else begin
         nxt = pend;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/clic_gateway_if.sv
// Bundle of raw lines, trigger attributes, software/claim traffic and pending outputs
// between the interrupt sources / register file / core and the CLIC gateway.
interface clic_gateway_if #(
   parameter int N_SOURCE = 32,
   parameter int ID_W     = $clog2(N_SOURCE)
);
   logic [N_SOURCE-1:0]   irq_i;
   logic [2*N_SOURCE-1:0] trig_i;
   logic [N_SOURCE-1:0]   ip_sw_we_i;
   logic [N_SOURCE-1:0]   ip_sw_wd_i;
   logic                  ack_i;
   logic [ID_W-1:0]       ack_id_i;
   logic [N_SOURCE-1:0]   ip_o;
   logic [N_SOURCE-1:0]   ip_de_o;
   logic [N_SOURCE-1:0]   ip_d_o;

   modport master (
      output irq_i, trig_i, ip_sw_we_i, ip_sw_wd_i, ack_i, ack_id_i,
      input  ip_o, ip_de_o, ip_d_o
   );

   modport slave (
      input  irq_i, trig_i, ip_sw_we_i, ip_sw_wd_i, ack_i, ack_id_i,
      output ip_o, ip_de_o, ip_d_o
   );
endinterface

// File: rtl/clic_gateway_cell.sv
// One gateway source: optional 2-flop synchronizer (CLIC_GATEWAY_SYNC_EN), raw-level history,
// pending bit and registered register-file update strobe.
module clic_gateway_cell
   import clic_gateway_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  irq_i,
   input  trig_t trig_i,
   input  logic  sw_we_i,
   input  logic  sw_wd_i,
   input  logic  ack_hit_i,
   output logic  pend_o,
   output logic  de_o
);
   logic irq_s;
   logic prev_q, prev_d;
   logic pend_q, pend_d;
   logic de_q, de_d;

`ifdef CLIC_GATEWAY_SYNC_EN
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   always_comb begin
      sync1_d = irq_i;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = irq_i;
`endif

   // prev_q tracks the raw level so a trigger change alone never fabricates an edge.
   always_comb begin
      prev_d = irq_s;
      pend_d = gw_pend_next(trig_i, irq_s, prev_q, ack_hit_i, sw_we_i, sw_wd_i, pend_q);
      de_d   = pend_d ^ pend_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q <= 1'b0;
         pend_q <= 1'b0;
         de_q   <= 1'b0;
      end else begin
         prev_q <= prev_d;
         pend_q <= pend_d;
         de_q   <= de_d;
      end
   end

   assign pend_o = pend_q;
   assign de_o   = de_q;

endmodule

// File: rtl/clic_gateway.sv
// CLIC interrupt gateway: per-source trigger conditioning and pending-state ownership.
// Define CLIC_GATEWAY_SYNC_EN to insert a 2-flop synchronizer on every irq line.
module clic_gateway
   import clic_gateway_pkg::*;
#(
   parameter int N_SOURCE = 32,
   parameter int ID_W     = $clog2(N_SOURCE)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   clic_gateway_if.slave  gw
);
   logic [N_SOURCE-1:0] ack_hit;
   logic [N_SOURCE-1:0] pend;
   logic [N_SOURCE-1:0] de;

   // Ids at or above N_SOURCE never match any index and are therefore ignored.
   always_comb begin
      ack_hit = '0;
      for (int i = 0; i < N_SOURCE; i++) begin
         ack_hit[i] = gw.ack_i && (gw.ack_id_i == ID_W'(i));
      end
   end

   for (genvar g = 0; g < N_SOURCE; g++) begin : g_cell
      clic_gateway_cell u_cell (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .irq_i     (gw.irq_i[g]),
         .trig_i    (trig_t'(gw.trig_i[2*g +: 2])),
         .sw_we_i   (gw.ip_sw_we_i[g]),
         .sw_wd_i   (gw.ip_sw_wd_i[g]),
         .ack_hit_i (ack_hit[g]),
         .pend_o    (pend[g]),
         .de_o      (de[g])
      );
   end

   assign gw.ip_o    = pend;
   assign gw.ip_d_o  = pend;
   assign gw.ip_de_o = de;

endmodule
